// File: rtl/gen_pipe_skid_buf_pkg.sv
// Shared definitions for the valid/ready skid-buffer pipeline stage.
// State encoding doubles as the occupancy count.
package gen_pipe_skid_buf_pkg;

  localparam logic [1:0] SKID_EMPTY = 2'd0;
  localparam logic [1:0] SKID_ONE   = 2'd1;
  localparam logic [1:0] SKID_TWO   = 2'd2;

  typedef enum logic [1:0] {
    S_EMPTY = SKID_EMPTY,
    S_ONE   = SKID_ONE,
    S_TWO   = SKID_TWO
  } skid_state_e;

  typedef struct packed {
    logic in_xfer;
    logic out_xfer;
  } skid_xfer_t;

  // Encoding 3 is unreachable; it reports as empty while it recovers.
  function automatic logic [1:0] skid_count(input skid_state_e st);
    return (st == S_TWO || st == S_ONE) ? st : SKID_EMPTY;
  endfunction

endpackage

// File: rtl/gen_en_dff.sv
// Enable-gated data register with asynchronous active-low clear to zero.
module gen_en_dff #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/gen_pipe_skid_buf.sv
// Valid/ready pipeline stage with a 2-entry skid buffer: full throughput while
// in_ready comes from registered state (only flush gates it combinationally).
module gen_pipe_skid_buf
  import gen_pipe_skid_buf_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic [DW-1:0] def_val,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    count
);

  skid_state_e   state_q, state_d;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] skid_q;
  logic          skid_en;
  skid_xfer_t    xfer;

  assign in_ready      = (state_q != S_TWO) & ~flush;
  assign out_valid     = (state_q == S_ONE) | (state_q == S_TWO);
  assign out_data      = main_q;
  assign count         = skid_count(state_q);
  assign xfer.in_xfer  = in_valid & in_ready;
  assign xfer.out_xfer = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_en = 1'b0;
    if (flush) begin
      state_d = S_EMPTY;
      main_d  = def_val;
    end else begin
      case (state_q)
        S_EMPTY: if (xfer.in_xfer) begin
          main_d  = in_data;
          state_d = S_ONE;
        end
        S_ONE: case ({xfer.in_xfer, xfer.out_xfer})
          2'b11:   main_d = in_data;
          2'b10: begin
            skid_en = 1'b1;
            state_d = S_TWO;
          end
          2'b01:   state_d = S_EMPTY;
          default: state_d = S_ONE;
        endcase
        S_TWO: if (xfer.out_xfer) begin
          main_d  = skid_q;
          state_d = S_ONE;
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // Main reg keeps its last value on drain; only reset/flush load the bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      main_q  <= def_val;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

  gen_en_dff #(.DW(DW)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (skid_en),
    .d     (in_data),
    .q     (skid_q)
  );

endmodule

// File: tb/tb_gen_pipe_skid_buf.sv
// Self-checking bench: queue-based model of a 2-deep FIFO stage, directed cases plus random traffic.
module tb_gen_pipe_skid_buf;
  localparam int DW = 32;
  localparam logic [DW-1:0] DEF = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [DW-1:0] def_val = DEF;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [1:0]    count;

  int n_chk = 0;
  int n_pass = 0;

  logic [DW-1:0] mq[$];
  logic [DW-1:0] shown = DEF;

  gen_pipe_skid_buf #(.DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .def_val   (def_val),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    shown = DEF;
  endtask

  // One cycle: drive inputs after negedge, compare against the model, then
  // advance the model to what the coming rising edge must produce.
  task automatic step(input logic iv, input logic [DW-1:0] id, input logic ordy, input logic fl);
    logic m_ready, m_valid, ix, ox;
    @(negedge clk);
    in_valid = iv; in_data = id; out_ready = ordy; flush = fl;
    #1;
    m_valid = (mq.size() > 0);
    m_ready = (mq.size() < 2) && !fl;
    check("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
    check("in_ready",  {63'd0, in_ready},  {63'd0, m_ready});
    check("count",     {62'd0, count},     64'(mq.size()));
    check("out_data",  {32'd0, out_data},  {32'd0, shown});
    ix = iv && m_ready;
    ox = m_valid && ordy;
    if (fl) begin
      mq.delete();
      shown = DEF;
    end else begin
      if (ox) void'(mq.pop_front());
      if (ix) mq.push_back(id);
      if (mq.size() > 0) shown = mq[0];
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    // 1: reset state, literal expectations
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready",  {63'd0, in_ready},  64'd1);
    check("rst_count",     {62'd0, count},     64'd0);
    check("rst_out_data",  {32'd0, out_data},  64'h13);
    @(negedge clk) rst_n = 1'b1;
    idle(2);

    // 2: back-to-back streaming
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, DW'(i), 1'b1, 1'b0);
      if (i > 1) check("stream_head", {32'd0, out_data}, 64'(i - 1));
    end
    step(1'b0, '0, 1'b1, 1'b0);
    check("stream_last", {32'd0, out_data}, 64'h8);
    step(1'b0, '0, 1'b1, 1'b0);
    check("drain_hold", {32'd0, out_data}, 64'h8);

    // 3: backpressure fills the skid, then drains in order
    step(1'b1, 32'hA, 1'b0, 1'b0);
    step(1'b1, 32'hB, 1'b0, 1'b0);
    step(1'b1, 32'hC, 1'b0, 1'b0);
    check("bp_count", {62'd0, count}, 64'd2);
    check("bp_in_ready", {63'd0, in_ready}, 64'd0);
    step(1'b1, 32'hC, 1'b1, 1'b0);
    check("bp_out_a", {32'd0, out_data}, 64'hA);
    step(1'b1, 32'hC, 1'b1, 1'b0);
    check("bp_out_b", {32'd0, out_data}, 64'hB);
    step(1'b0, '0, 1'b1, 1'b0);
    check("bp_out_c", {32'd0, out_data}, 64'hC);
    idle(2);

    // 4: flush while full with a pending input
    step(1'b1, 32'hA, 1'b0, 1'b0);
    step(1'b1, 32'hB, 1'b0, 1'b0);
    step(1'b1, 32'hC, 1'b0, 1'b1);
    check("fl_in_ready", {63'd0, in_ready}, 64'd0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("fl_count", {62'd0, count}, 64'd0);
    check("fl_out_valid", {63'd0, out_valid}, 64'd0);
    check("fl_out_data", {32'd0, out_data}, 64'h13);
    idle(2);

    // 5: asynchronous reset while full
    step(1'b1, 32'h11, 1'b0, 1'b0);
    step(1'b1, 32'h22, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    check("ar_pre_count", {62'd0, count}, 64'd2);
    #1 rst_n = 1'b0;
    #1;
    check("ar_out_valid", {63'd0, out_valid}, 64'd0);
    check("ar_in_ready",  {63'd0, in_ready},  64'd1);
    check("ar_count",     {62'd0, count},     64'd0);
    check("ar_out_data",  {32'd0, out_data},  64'h13);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    step(1'b1, 32'h55, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("ar_out_55", {32'd0, out_data}, 64'h55);
    check("ar_valid_55", {63'd0, out_valid}, 64'd1);
    step(1'b0, '0, 1'b1, 1'b0);
    check("ar_empty", {63'd0, out_valid}, 64'd0);

    // 6: random traffic against the queue model
    for (int i = 0; i < 10000; i++)
      step(1'($urandom_range(0, 3) != 0), $urandom(), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 63) == 0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
